uart_tx_fifo: RTL and testbench

Parametrised UART transmitter: a successor to the fixed 8N1 transmitter, feeding the USB-UART debug terminal link from the FPGA core logic. Adds a write-side FIFO with a valid/ready handshake, so producers can queue bursts of bytes. Frame format is selectable at elaboration: 5–9 data bits, none/even/odd parity, and 1 or 2 stop bits. Consecutive frames go out back-to-back with no idle gap.

---
 rtl/uart_tx_fifo.sv | 211 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Parametrised UART transmitter with a write-side FIFO.
//            The frame format is fixed at elaboration: data bits, parity mode
//            and stop bits. Queued words are sent back-to-back.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          uart_tx,
    output logic                          uart_tx_busy,
    output logic                          tx_done
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0]   CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    // Registered tx_done must be set one cycle early to line up with the
    // last stop-bit cycle.
    localparam logic [CW-1:0]   CNT_DONE   = CW'(CLKS_PER_BIT - 2);
    localparam logic [3:0]      DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(FIFO_DEPTH);
    localparam bit              HAS_PARITY = (PARITY != 0);
    localparam bit              ODD_PARITY = (PARITY == 2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CNTW-1:0]      count;

    state_t               state;
    logic [CW-1:0]        bit_cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 parity_bit;

    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 stop_end;
    logic [DATA_BITS-1:0] head;
    logic                 head_parity;

    // Readiness depends only on the current occupancy, never on a same-cycle pop.
    assign tx_ready    = !reset && (count != FULL_COUNT);
    assign fifo_count  = count;
    assign push        = tx_valid && tx_ready;
    assign bit_end     = (bit_cnt == CNT_LAST);
    assign stop_end    = (state == ST_STOP) && bit_end && (bit_idx == STOP_LAST);
    assign pop         = (count != '0) && ((state == ST_IDLE) || stop_end);
    assign head        = mem[rd_ptr];
    assign head_parity = ODD_PARITY ? ~(^head) : (^head);

    // FIFO storage: written on every accepted push, contents need no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Frame sequencer with registered line, busy and done outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            uart_tx      <= 1'b1;
            uart_tx_busy <= 1'b0;
            tx_done      <= 1'b0;
            bit_cnt      <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            parity_bit   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    uart_tx      <= 1'b1;
                    uart_tx_busy <= 1'b0;
                    bit_cnt      <= '0;
                    bit_idx      <= '0;
                    if (pop) begin
                        shift        <= head;
                        parity_bit   <= head_parity;
                        uart_tx      <= 1'b0;
                        uart_tx_busy <= 1'b1;
                        state        <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        uart_tx <= shift[0];
                        state   <= ST_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            if (HAS_PARITY) begin
                                uart_tx <= parity_bit;
                                state   <= ST_PARITY;
                            end else begin
                                uart_tx <= 1'b1;
                                state   <= ST_STOP;
                            end
                        end else begin
                            // Shift right so the next bit always sits at index 1.
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= shift >> 1;
                            uart_tx <= shift[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        uart_tx <= 1'b1;
                        state   <= ST_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if ((bit_idx == STOP_LAST) && (bit_cnt == CNT_DONE)) begin
                        tx_done <= 1'b1;
                    end
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx != STOP_LAST) begin
                            bit_idx <= bit_idx + 1'b1;
                        end else if (pop) begin
                            // Next queued word starts with no idle gap.
                            bit_idx    <= '0;
                            shift      <= head;
                            parity_bit <= head_parity;
                            uart_tx    <= 1'b0;
                            state      <= ST_START;
                        end else begin
                            bit_idx      <= '0;
                            uart_tx      <= 1'b1;
                            uart_tx_busy <= 1'b0;
                            state        <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    uart_tx      <= 1'b1;
                    uart_tx_busy <= 1'b0;
                    bit_cnt      <= '0;
                    bit_idx      <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Directed bench for uart_tx_fifo across four frame formats
//            (8N1, 8E1, 8O1, 5N2), all at 4 clocks per bit, FIFO depth 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    logic       clock;
    logic       reset;
    logic       valid;
    logic [7:0] data;
    int         sel;

    logic       valid_a, valid_e, valid_o, valid_s;
    logic       ready_a, ready_e, ready_o, ready_s;
    logic       tx_a, tx_e, tx_o, tx_s;
    logic       busy_a, busy_e, busy_o, busy_s;
    logic       done_a, done_e, done_o, done_s;
    logic [2:0] cnt_a, cnt_e, cnt_o, cnt_s;

    logic       line, busy, done, ready;
    logic [2:0] cnt;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic line_rec [0:240];
    logic busy_rec [0:240];
    logic done_rec [0:240];

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clock(clock), .reset(reset), .tx_valid(valid_a), .tx_data(data), .tx_ready(ready_a),
        .fifo_count(cnt_a), .uart_tx(tx_a), .uart_tx_busy(busy_a), .tx_done(done_a));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
        .clock(clock), .reset(reset), .tx_valid(valid_e), .tx_data(data), .tx_ready(ready_e),
        .fifo_count(cnt_e), .uart_tx(tx_e), .uart_tx_busy(busy_e), .tx_done(done_e));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_o (
        .clock(clock), .reset(reset), .tx_valid(valid_o), .tx_data(data), .tx_ready(ready_o),
        .fifo_count(cnt_o), .uart_tx(tx_o), .uart_tx_busy(busy_o), .tx_done(done_o));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_s (
        .clock(clock), .reset(reset), .tx_valid(valid_s), .tx_data(data[4:0]), .tx_ready(ready_s),
        .fifo_count(cnt_s), .uart_tx(tx_s), .uart_tx_busy(busy_s), .tx_done(done_s));

    assign valid_a = valid && (sel == 0);
    assign valid_e = valid && (sel == 1);
    assign valid_o = valid && (sel == 2);
    assign valid_s = valid && (sel == 3);

    // Route the selected instance's outputs to common observation signals.
    always_comb begin
        line  = 1'b1;
        busy  = 1'b0;
        done  = 1'b0;
        ready = 1'b0;
        cnt   = '0;
        case (sel)
            0: begin line = tx_a; busy = busy_a; done = done_a; ready = ready_a; cnt = cnt_a; end
            1: begin line = tx_e; busy = busy_e; done = done_e; ready = ready_e; cnt = cnt_e; end
            2: begin line = tx_o; busy = busy_o; done = done_o; ready = ready_o; cnt = cnt_o; end
            3: begin line = tx_s; busy = busy_s; done = done_s; ready = ready_s; cnt = cnt_s; end
            default: ;
        endcase
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Free-running edge counter used to time handshake events.
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Push one word into an idle instance and check the whole frame cycle by cycle.
    task automatic send_frame(input int s, input logic [7:0] d, input int nbits,
                              input logic [12:0] lv, input string nm);
        int last;
        int ndone;
        int nbusy;
        @(negedge clock);
        sel   = s;
        data  = d;
        valid = 1'b1;
        @(posedge clock);
        #1;
        valid = 1'b0;
        chk({nm, " count after push"}, 32'(cnt), 32'd1);
        chk({nm, " line before pop"}, 32'(line), 32'd1);
        last  = nbits * 4;
        ndone = 0;
        nbusy = 0;
        for (int c = 0; c < last; c++) begin
            @(posedge clock);
            #1;
            chk($sformatf("%s line c%0d", nm, c), 32'(line), 32'(lv[c / 4]));
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                chk($sformatf("%s done position", nm), 32'(c), 32'(last - 1));
            end
        end
        chk({nm, " busy cycles"}, 32'(nbusy), 32'(last));
        chk({nm, " done pulses"}, 32'(ndone), 32'd1);
        @(posedge clock);
        #1;
        chk({nm, " idle line"}, 32'(line), 32'd1);
        chk({nm, " idle busy"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        int          sel;
        logic [7:0]  data;
        int          nbits;
        logic [12:0] levels;   // bit i = line level of serial bit i (0 = start)
    } vec_t;

    vec_t vecs [0:8];

    int         base;
    int         acc_edge;
    int         guard;
    int         ndone_tot;
    int         nbusy_tot;
    int         bad;
    logic       accepted;
    logic       rdy;
    logic [7:0] got;

    initial begin
        vecs[0] = '{0, 8'h55, 10, 13'b1010101010};
        vecs[1] = '{0, 8'h00, 10, 13'b1000000000};
        vecs[2] = '{0, 8'hFF, 10, 13'b1111111110};
        vecs[3] = '{1, 8'h07, 11, 13'b11000001110};
        vecs[4] = '{1, 8'h00, 11, 13'b10000000000};
        vecs[5] = '{2, 8'h07, 11, 13'b10000001110};
        vecs[6] = '{2, 8'h00, 11, 13'b11000000000};
        vecs[7] = '{3, 8'h1F,  8, 13'b11111110};
        vecs[8] = '{3, 8'h0A,  8, 13'b11010100};

        sel   = 0;
        valid = 1'b0;
        data  = '0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("reset line", 32'(line), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset count", 32'(cnt), 32'd0);
        chk("reset ready", 32'(ready), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("ready after reset", 32'(ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].nbits, vecs[i].levels,
                       $sformatf("vec%0d", i));
        end

        // FIFO fill: six consecutive offers into a depth-4 queue.
        @(negedge clock);
        sel   = 0;
        valid = 1'b1;
        base  = cyc;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    data = 8'hA0 + 8'(i);
                    @(posedge clock);
                    #1;
                    if (i == 1) chk("fill count push+pop", 32'(cnt), 32'd1);
                    if (i == 4) begin
                        chk("fill count full", 32'(cnt), 32'd4);
                        chk("fill ready full", 32'(ready), 32'd0);
                    end
                    @(negedge clock);
                end
                accepted = 1'b0;
                acc_edge = 0;
                guard    = 0;
                while (!accepted && guard < 200) begin
                    rdy = ready;
                    @(posedge clock);
                    #1;
                    if (rdy) begin
                        accepted = 1'b1;
                        acc_edge = cyc - base;
                    end else begin
                        @(negedge clock);
                    end
                    guard++;
                end
                valid = 1'b0;
                chk("fill A5 accepted", 32'(accepted), 32'd1);
                chk("fill A5 accept edge", 32'(acc_edge), 32'd43);
                chk("fill count after A5", 32'(cnt), 32'd4);
            end
            begin
                @(posedge clock);
                @(posedge clock);
                #1;
                for (int c = 0; c < 241; c++) begin
                    line_rec[c] = line;
                    busy_rec[c] = busy;
                    done_rec[c] = done;
                    @(posedge clock);
                    #1;
                end
            end
        join

        ndone_tot = 0;
        nbusy_tot = 0;
        for (int c = 0; c < 240; c++) begin
            if (done_rec[c]) ndone_tot++;
            if (busy_rec[c]) nbusy_tot++;
        end
        for (int f = 0; f < 6; f++) begin
            got = '0;
            for (int b = 0; b < 8; b++) got[b] = line_rec[f * 40 + (1 + b) * 4 + 2];
            chk($sformatf("fill frame%0d start", f), 32'(line_rec[f * 40 + 2]), 32'd0);
            chk($sformatf("fill frame%0d data", f), 32'(got), 32'hA0 + 32'(f));
            chk($sformatf("fill frame%0d stop", f), 32'(line_rec[f * 40 + 38]), 32'd1);
            chk($sformatf("fill frame%0d done", f), 32'(done_rec[f * 40 + 39]), 32'd1);
        end
        chk("fill done pulses", 32'(ndone_tot), 32'd6);
        chk("fill busy no gap", 32'(nbusy_tot), 32'd240);
        chk("fill idle line", 32'(line_rec[240]), 32'd1);
        chk("fill idle busy", 32'(busy_rec[240]), 32'd0);

        // Reset during data bit 3 with two words still queued.
        @(negedge clock);
        sel   = 0;
        valid = 1'b1;
        data  = 8'h11;
        @(posedge clock);
        @(negedge clock);
        data = 8'h22;
        @(posedge clock);
        @(negedge clock);
        data = 8'h33;
        @(posedge clock);
        #1;
        valid = 1'b0;
        chk("midreset queued", 32'(cnt), 32'd2);
        repeat (16) @(posedge clock);
        #1;
        chk("midreset in data bit3", 32'(line), 32'd0);
        chk("midreset busy before", 32'(busy), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midreset line", 32'(line), 32'd1);
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset done", 32'(done), 32'd0);
        chk("midreset count", 32'(cnt), 32'd0);
        chk("midreset ready", 32'(ready), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clock);
            #1;
            if (line !== 1'b1 || busy !== 1'b0 || cnt !== 3'd0) bad++;
        end
        chk("postreset quiet cycles", 32'(bad), 32'd0);
        send_frame(0, 8'h3C, 10, 13'b1001111000, "postreset 3C");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
